// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx serializer among NUM_REQ byte producers.
// Define UART_ARB_LOCK_EN to keep the grant on one requester until its req_last byte.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic [ID_W-1:0]        grant_id,
  output logic                   active
);

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]     sel_id;
  logic [ID_W-1:0]     next_ptr;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [DATA_W-1:0]   sel_data;
  logic                tx_start_q, tx_start_d;
  logic                active_q, active_d;
  logic [NUM_REQ-1:0]  cand;
  logic [NUM_REQ-1:0]  sel_oh;
  logic                found;
  logic                accept;
  logic                locked;
  int unsigned         best_dist;

`ifdef UART_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic sel_last;

  assign locked   = lock_q;
  assign sel_last = |(req_last & sel_oh);
`else
  logic unused_last;

  assign locked      = 1'b0;
  assign unused_last = ^req_last;
`endif

  // Rotating priority: the valid requester closest to ptr (modulo NUM_REQ) wins.
  always_comb begin
    cand      = '0;
    best_dist = NUM_REQ;
    sel_id    = '0;
    found     = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      cand[j] = req_valid[j] && (!locked || (grant_q == ID_W'(j)));
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (cand[j] && (((j + NUM_REQ - 32'(ptr_q)) % NUM_REQ) < best_dist)) begin
        best_dist = (j + NUM_REQ - 32'(ptr_q)) % NUM_REQ;
        sel_id    = ID_W'(j);
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    sel_oh   = '0;
    sel_data = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (sel_id == ID_W'(j)) begin
        sel_oh[j] = found;
        sel_data  = req_data[DATA_W*j +: DATA_W];
      end
    end
  end

  assign accept    = found && rst_n && (state_q == S_IDLE);
  assign req_ready = accept ? sel_oh : '0;
  assign next_ptr  = ID_W'((32'(grant_q) + 32'd1) % NUM_REQ);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    active_d   = active_q;
`ifdef UART_ARB_LOCK_EN
    lock_d     = lock_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_LAUNCH;
          tx_start_d = 1'b1;
          tx_data_d  = sel_data;
          grant_d    = sel_id;
          active_d   = 1'b1;
`ifdef UART_ARB_LOCK_EN
          lock_d     = ~sel_last;
`endif
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_BUSY;
      end
      // A leftover tx_done from the previous frame must not end this one.
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (tx_done) begin
          state_d  = S_IDLE;
          active_d = 1'b0;
          if (!locked) begin
            ptr_d = next_ptr;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      active_q   <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      active_q   <= active_d;
`ifdef UART_ARB_LOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;
  assign active   = active_q;

endmodule
